md_sched: RTL and testbench



---
 rtl/md_pkg.sv | 41 ++++
 rtl/md_sched_if.sv | 27 ++
 rtl/md_lat_cnt.sv | 29 ++
 rtl/md_sched.sv | 132 +++++++++++++
 tb/tb_md_sched.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencing controller:
// E-stage MD op encodings, controller state encoding and MD unit op selects.
package md_pkg;

  // MD-class op encodings carried on e_op
  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  // MD unit op select driven on md_ctrl
  localparam logic [1:0] MD_CTRL_MULTU = 2'b00;
  localparam logic [1:0] MD_CTRL_MULT  = 2'b01;
  localparam logic [1:0] MD_CTRL_DIVU  = 2'b10;
  localparam logic [1:0] MD_CTRL_DIV   = 2'b11;

  // Controller states: idle, or occupied by a multiply or a divide
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10
  } md_state_e;

  // Op class helpers: the two top op bits select mult/div/mt/mf
  function automatic logic op_is_mult(input logic [2:0] op);
    return op[2:1] == 2'b00;
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

  function automatic logic op_is_mt(input logic [2:0] op);
    return op[2:1] == 2'b10;
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// Bundle of E/D-stage request signals and MD unit strobes around md_sched.
// The master side is the pipeline/MD datapath, the slave side is md_sched.
interface md_sched_if;
  logic       e_valid;
  logic [2:0] e_op;
  logic       e_flush;
  logic       e_b_zero;
  logic       d_md_use;
  logic       md_start;
  logic [1:0] md_ctrl;
  logic       md_write;
  logic       md_hilo;
  logic       busy;
  logic       stall_d;
  logic       done;
  logic       div0;

  modport master (
    output e_valid, e_op, e_flush, e_b_zero, d_md_use,
    input  md_start, md_ctrl, md_write, md_hilo, busy, stall_d, done, div0
  );

  modport slave (
    input  e_valid, e_op, e_flush, e_b_zero, d_md_use,
    output md_start, md_ctrl, md_write, md_hilo, busy, stall_d, done, div0
  );
endinterface

// File: rtl/md_lat_cnt.sv
// Loadable latency down-counter for the MD controller.
// Load wins over decrement; decrement saturates at zero.
module md_lat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         is_zero,
  output logic         is_one
);

  // Counter register: load a fresh latency or count down towards zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign is_zero = (cnt == '0);
  assign is_one  = (cnt == W'(1));

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencing controller for the E stage.
// Issues start/control/HI-LO write strobes, tracks latency and stalls D.
// Optional feature macro MD_SCHED_DIV0_EN: suppress divides by zero and
// pulse div0 instead of occupying the unit.
module md_sched
  import md_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic           clk,
  input  logic           reset,
  md_sched_if.slave      bus
);

  md_state_e        state;
  md_state_e        state_next;
  logic             busy_r, busy_next;
  logic             done_r, done_next;
  logic             div0_r, div0_next;
  logic             issue, is_mult, is_div, is_mt;
  logic             div_zero, start;
  logic             cnt_load, cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero, cnt_one;

  md_lat_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .is_zero  (cnt_zero),
    .is_one   (cnt_one)
  );

`ifdef MD_SCHED_DIV0_EN
  // Divide by zero is caught at issue and never reaches the MD unit
  always_comb begin
    div_zero = issue & is_div & bus.e_b_zero;
  end
`else
  logic unused_b_zero;
  assign unused_b_zero = bus.e_b_zero;

  // Without the feature a zero divisor runs as a normal divide
  always_comb begin
    div_zero = 1'b0;
  end
`endif

  // Decode the E-stage op; ops arriving while occupied are ignored
  always_comb begin
    is_mult = op_is_mult(bus.e_op);
    is_div  = op_is_div(bus.e_op);
    is_mt   = op_is_mt(bus.e_op);
    issue   = bus.e_valid & ~bus.e_flush & (state == S_IDLE) & ~reset;
    start   = issue & (is_mult | (is_div & ~div_zero));
  end

  // State, occupancy and pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      div0_r <= 1'b0;
    end else begin
      state  <= state_next;
      busy_r <= busy_next;
      done_r <= done_next;
      div0_r <= div0_next;
    end
  end

  // Next-state logic; done is timed to mark the last occupied cycle
  always_comb begin
    state_next   = state;
    busy_next    = busy_r;
    done_next    = 1'b0;
    div0_next    = div_zero;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && is_mult) begin
          state_next   = S_MUL;
          busy_next    = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(MUL_LAT);
          done_next    = (MUL_LAT == 1);
        end else if (start && is_div) begin
          state_next   = S_DIV;
          busy_next    = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(DIV_LAT);
          done_next    = (DIV_LAT == 1);
        end
      end
      S_MUL, S_DIV: begin
        cnt_dec = 1'b1;
        if (cnt == CNT_W'(2))
          done_next = 1'b1;
        if (cnt_one || cnt_zero) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Strobes to the MD unit and the D-stage stall
  always_comb begin
    bus.md_start = start;
    bus.md_ctrl  = start ? bus.e_op[1:0] : MD_CTRL_MULTU;
    bus.md_write = issue & is_mt;
    bus.md_hilo  = ~reset & (bus.e_op == OP_MTHI);
    bus.busy     = busy_r;
    bus.stall_d  = bus.d_md_use & (busy_r | start);
    bus.done     = done_r;
    bus.div0     = div0_r;
  end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: a cycle-level model built from the
// start cycle and latency of the last issued op, plus directed literal checks.
// Honours MD_SCHED_DIV0_EN when compiled with it.
module tb_md_sched;
  import md_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic clk = 1'b0;
  logic reset;
  md_sched_if bus();

  md_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int start_cyc = -1000;
  int lat = 0;
  int div0_cyc = -1000;

  // Cycle index advances on every rising edge
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [2:0] op, input logic fl,
                                input logic bz, input logic du);
    @(posedge clk);
    #1;
    bus.e_valid  = v;
    bus.e_op     = op;
    bus.e_flush  = fl;
    bus.e_b_zero = bz;
    bus.d_md_use = du;
  endtask

  // Model: the unit is occupied for lat cycles after the start cycle
  always @(negedge clk) begin : model_check
    logic       e_busy, e_done, e_issue, e_dz, e_start, e_write, e_hilo, e_stall, e_div0;
    logic [1:0] e_ctrl;
    logic [1:0] cls;
    cls = bus.e_op[2:1];
    if (reset) begin
      start_cyc = -1000;
      div0_cyc  = -1000;
      e_busy = 0; e_done = 0; e_start = 0; e_write = 0; e_hilo = 0;
      e_stall = 0; e_div0 = 0; e_ctrl = 0; e_dz = 0;
    end else begin
      e_busy  = (cyc > start_cyc) && (cyc <= start_cyc + lat);
      e_done  = (cyc == start_cyc + lat);
      e_issue = bus.e_valid && !bus.e_flush && !e_busy;
`ifdef MD_SCHED_DIV0_EN
      e_dz    = e_issue && (cls == 2'd1) && bus.e_b_zero;
`else
      e_dz    = 1'b0;
`endif
      e_start = e_issue && ((cls == 2'd0) || ((cls == 2'd1) && !e_dz));
      e_ctrl  = e_start ? bus.e_op[1:0] : 2'd0;
      e_write = e_issue && (cls == 2'd2);
      e_hilo  = (bus.e_op == 3'b100);
      e_stall = bus.d_md_use && (e_busy || e_start);
      e_div0  = (cyc == div0_cyc + 1);
    end
    check_output("model md_start", int'(bus.md_start), int'(e_start));
    check_output("model md_ctrl",  int'(bus.md_ctrl),  int'(e_ctrl));
    check_output("model md_write", int'(bus.md_write), int'(e_write));
    check_output("model md_hilo",  int'(bus.md_hilo),  int'(e_hilo));
    check_output("model busy",     int'(bus.busy),     int'(e_busy));
    check_output("model stall_d",  int'(bus.stall_d),  int'(e_stall));
    check_output("model done",     int'(bus.done),     int'(e_done));
    check_output("model div0",     int'(bus.div0),     int'(e_div0));
    if (!reset) begin
      if (e_start) begin
        start_cyc = cyc;
        lat = (cls == 2'd0) ? MUL_LAT : DIV_LAT;
      end
      if (e_dz) div0_cyc = cyc;
    end
  end

  // Directed scenarios with hand-computed literal expectations
  initial begin
    logic [6:0]  mul_busy_pat;
    logic [6:0]  mul_done_pat;
    logic [11:0] div_stall_pat;
    logic [11:0] div_done_pat;
    mul_busy_pat  = 7'b0111110;
    mul_done_pat  = 7'b0100000;
    div_stall_pat = 12'b011111111111;
    div_done_pat  = 12'b010000000000;

    reset = 1'b1;
    bus.e_valid = 0; bus.e_op = 3'b000; bus.e_flush = 0; bus.e_b_zero = 0; bus.d_md_use = 0;

    // Under reset the combinational strobes stay low even with a request
    @(negedge clk);
    #1;
    bus.e_valid = 1; bus.e_op = OP_MULT; bus.d_md_use = 1;
    #1;
    check_output("reset md_start", int'(bus.md_start), 0);
    check_output("reset stall_d",  int'(bus.stall_d),  0);
    check_output("reset busy",     int'(bus.busy),     0);
    check_output("reset done",     int'(bus.done),     0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.e_valid = 0; bus.d_md_use = 0;

    // MULT: busy cycles 1-5, done in cycle 5
    $display("[TB] MULT latency");
    apply_stimulus(1, OP_MULT, 0, 0, 0);
    @(negedge clk);
    check_output("mult md_start", int'(bus.md_start), 1);
    check_output("mult md_ctrl",  int'(bus.md_ctrl),  1);
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(0, OP_MULTU, 0, 0, 0);
      @(negedge clk);
      check_output("mult busy", int'(bus.busy), int'(mul_busy_pat[k]));
      check_output("mult done", int'(bus.done), int'(mul_done_pat[k]));
    end

    // DIVU with MFLO waiting in D; stray ops during the divide are ignored
    $display("[TB] DIVU with MFLO in D");
    apply_stimulus(1, OP_DIVU, 0, 0, 1);
    @(negedge clk);
    check_output("divu md_ctrl", int'(bus.md_ctrl), 2);
    check_output("divu stall_d", int'(bus.stall_d), 1);
    for (int k = 1; k <= 11; k++) begin
      if (k == 3)      apply_stimulus(1, OP_MULT, 0, 0, 1);
      else if (k == 5) apply_stimulus(1, OP_MTHI, 0, 0, 1);
      else             apply_stimulus(0, OP_MFLO, 0, 0, 1);
      @(negedge clk);
      check_output("divu stall_d", int'(bus.stall_d), int'(div_stall_pat[k]));
      check_output("divu done",    int'(bus.done),    int'(div_done_pat[k]));
      if (k == 3) check_output("busy ignores start", int'(bus.md_start), 0);
      if (k == 5) check_output("busy ignores write", int'(bus.md_write), 0);
    end

    // MTHI then MTLO while idle
    $display("[TB] MTHI/MTLO");
    apply_stimulus(1, OP_MTHI, 0, 0, 1);
    @(negedge clk);
    check_output("mthi md_write", int'(bus.md_write), 1);
    check_output("mthi md_hilo",  int'(bus.md_hilo),  1);
    check_output("mthi stall_d",  int'(bus.stall_d),  0);
    apply_stimulus(1, OP_MTLO, 0, 0, 1);
    @(negedge clk);
    check_output("mtlo md_write", int'(bus.md_write), 1);
    check_output("mtlo md_hilo",  int'(bus.md_hilo),  0);
    check_output("mtlo busy",     int'(bus.busy),     0);

    // DIV interrupted by reset in cycle 4, MULTU restarts in cycle 6
    $display("[TB] reset mid-divide");
    apply_stimulus(1, OP_DIV, 0, 0, 0);
    for (int k = 1; k <= 4; k++) apply_stimulus(0, OP_MULTU, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_output("async reset busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply_stimulus(1, OP_MULTU, 0, 0, 0);
    @(negedge clk);
    check_output("restart md_start", int'(bus.md_start), 1);
    check_output("restart md_ctrl",  int'(bus.md_ctrl),  0);
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(0, OP_MULTU, 0, 0, 0);
      @(negedge clk);
      check_output("restart busy", int'(bus.busy), int'(mul_busy_pat[k]));
      check_output("restart done", int'(bus.done), int'(mul_done_pat[k]));
    end

    // Flushed request neither starts nor stalls
    $display("[TB] flush");
    apply_stimulus(1, OP_MULT, 1, 0, 1);
    @(negedge clk);
    check_output("flush md_start", int'(bus.md_start), 0);
    check_output("flush stall_d",  int'(bus.stall_d),  0);
    apply_stimulus(0, OP_MULTU, 0, 0, 1);
    @(negedge clk);
    check_output("flush busy", int'(bus.busy), 0);

    // Divide by zero
    $display("[TB] divide by zero");
    apply_stimulus(1, OP_DIV, 0, 1, 0);
    @(negedge clk);
`ifdef MD_SCHED_DIV0_EN
    check_output("div0 md_start", int'(bus.md_start), 0);
    apply_stimulus(0, OP_MULTU, 0, 0, 0);
    @(negedge clk);
    check_output("div0 pulse", int'(bus.div0), 1);
    check_output("div0 busy",  int'(bus.busy), 0);
    apply_stimulus(0, OP_MULTU, 0, 0, 0);
    @(negedge clk);
    check_output("div0 pulse end", int'(bus.div0), 0);
`else
    check_output("div0 md_start", int'(bus.md_start), 1);
    check_output("div0 md_ctrl",  int'(bus.md_ctrl),  3);
    for (int k = 1; k <= 11; k++) begin
      apply_stimulus(0, OP_MULTU, 0, 0, 1);
      @(negedge clk);
      check_output("div0 stall_d", int'(bus.stall_d), int'(div_stall_pat[k]));
      check_output("div0 done",    int'(bus.done),    int'(div_done_pat[k]));
      check_output("div0 tied",    int'(bus.div0),    0);
    end
`endif

    apply_stimulus(0, OP_MULTU, 0, 0, 0);
    apply_stimulus(0, OP_MULTU, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
